keypad_event_queue: RTL and testbench



---
 rtl/keypad_event_queue.sv | 199 +++++++++++++++++++
 tb/tb_keypad_event_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_queue.sv
// Debounces button-matrix scanner reports, turns accepted presses into {V,H} key codes
// and queues them for the text/cursor logic. Define KEYPAD_REPEAT_EN for held-key auto-repeat.
module keypad_event_queue #(
    parameter int DEBOUNCE_SCANS  = 3,
    parameter int RELEASE_TIMEOUT = 16,
    parameter int DEPTH           = 8,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [1:0]               H,
    input  logic [1:0]               V,
    input  logic                     Y,
    input  logic                     POP,
    output logic [3:0]               KEY,
    output logic                     VALID,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(RELEASE_TIMEOUT + 1);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("keypad_event_queue: DEPTH must be a power of two in 2..16");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("keypad_event_queue: DEBOUNCE_SCANS must be 1..15");
    end
    if (RELEASE_TIMEOUT <= 11) begin : g_bad_timeout
        $error("keypad_event_queue: RELEASE_TIMEOUT must exceed the 11-cycle scan period");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
        $error("keypad_event_queue: need 1 <= REPEAT_RATE <= REPEAT_DELAY");
    end

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      mcnt_q, mcnt_d;
    logic [SW-1:0]   sil_q, sil_d;
    logic            push_q, push_d;
    logic [3:0]      push_code_q, push_code_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      key_hold_q, key_hold_d;
    logic [3:0]      mem_q [DEPTH];

    logic [3:0] code;
    logic       timeout, full, do_pop, do_push, rpt_push;

    assign code    = {V, H};
    assign timeout = !Y && (sil_q == SW'(RELEASE_TIMEOUT));

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rpt_q, rpt_d;

    // Counts matching scans while held; anything else (entry, code change, timeout) restarts it.
    always_comb begin
        rpt_d    = '0;
        rpt_push = 1'b0;
        if (state_q == S_HELD) begin
            if (Y && code == cand_q) begin
                if (rpt_q + 1'b1 == RW'(REPEAT_DELAY)) begin
                    rpt_push = 1'b1;
                    rpt_d    = RW'(REPEAT_DELAY - REPEAT_RATE);
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end else if (!Y && !timeout) begin
                rpt_d = rpt_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) rpt_q <= '0;
        else     rpt_q <= rpt_d;
    end
`else
    assign rpt_push = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        mcnt_d      = mcnt_q;
        push_d      = rpt_push;
        push_code_d = cand_q;
        sil_d       = Y ? '0 : ((sil_q == SW'(RELEASE_TIMEOUT)) ? sil_q : sil_q + 1'b1);
        if (Y) cand_d = code;

        case (state_q)
            S_IDLE: begin
                if (Y) begin
                    if (DEBOUNCE_SCANS == 1) begin
                        state_d = S_HELD;
                        push_d  = 1'b1;
                    end else begin
                        state_d = S_DEBOUNCE;
                        mcnt_d  = 4'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (Y) begin
                    if (code == cand_q) begin
                        mcnt_d = mcnt_q + 4'd1;
                        if (mcnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                            state_d = S_HELD;
                            push_d  = 1'b1;
                        end
                    end else if (DEBOUNCE_SCANS == 1) begin
                        state_d = S_HELD;
                        push_d  = 1'b1;
                    end else begin
                        mcnt_d = 4'd1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_HELD: begin
                if (Y) begin
                    if (code != cand_q) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            push_d = 1'b1;
                        end else begin
                            state_d = S_DEBOUNCE;
                            mcnt_d  = 4'd1;
                        end
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_d) push_code_d = cand_d;
    end

    // A pop frees a slot in the same edge, so a full FIFO still accepts a simultaneous push.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        do_pop     = POP && (count_q != '0);
        do_push    = push_q && (!full || do_pop);
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        key_hold_d = do_pop  ? mem_q[rd_ptr_q] : key_hold_q;
        ovf_d      = ovf_q | (push_q && full && !do_pop);
        count_d    = count_q;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            mcnt_q      <= '0;
            sil_q       <= '0;
            push_q      <= 1'b0;
            push_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            key_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            mcnt_q      <= mcnt_d;
            sil_q       <= sil_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            key_hold_q  <= key_hold_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_code_q;
    end

    // When empty, KEY keeps showing the last entry handed out.
    assign VALID = (count_q != '0);
    assign KEY   = VALID ? mem_q[rd_ptr_q] : key_hold_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue: debounce, timeout, FIFO order/overflow, optional repeat.
module tb_keypad_event_queue;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] H = '0, V = '0;
    logic       Y = 1'b0, POP = 1'b0;
    logic [3:0] KEY;
    logic       VALID;
    logic [3:0] COUNT;
    logic       OVF;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_event_queue dut (
        .CLK(CLK), .RST(RST), .H(H), .V(V), .Y(Y), .POP(POP),
        .KEY(KEY), .VALID(VALID), .COUNT(COUNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One scanner report followed by the rest of an 11-cycle scan.
    task automatic scan(input logic [3:0] c);
        {V, H} = c; Y = 1'b1; tick(); Y = 1'b0; idle(10);
    endtask

    task automatic press(input logic [3:0] c);
        repeat (3) scan(c);
        idle(20);
    endtask

    task automatic pop_one();
        POP = 1'b1; tick(); POP = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1; Y = 1'b0; POP = 1'b0; idle(2); RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            H = 2'($urandom); V = 2'($urandom); Y = 1'($urandom); tick();
        end
        RST = 1'b0; Y = 1'b0;
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0d want 0", VALID); end
        n_cmp++; if (COUNT !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", COUNT); end
        n_cmp++; if (OVF !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %0d want 0", OVF); end
        n_cmp++; if (KEY !== 4'd0)   begin n_bad++; $display("FAIL reset_key: got %0d want 0", KEY); end
        idle(50);
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %0d want 0", VALID); end
        n_cmp++; if (COUNT !== 4'd0) begin n_bad++; $display("FAIL idle_count: got %0d want 0", COUNT); end
    endtask

    task automatic test_press();
        do_reset();
        scan(4'd6); scan(4'd6);
        H = 2'd2; V = 2'd1; Y = 1'b1; tick(); Y = 1'b0;
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL press_t1_valid: got %0d want 0", VALID); end
        tick();
        n_cmp++; if (VALID !== 1'b1) begin n_bad++; $display("FAIL press_t2_valid: got %0d want 1", VALID); end
        n_cmp++; if (KEY !== 4'd6)   begin n_bad++; $display("FAIL press_key: got %0d want 6", KEY); end
        idle(9);
        repeat (20) scan(4'd6);
        n_cmp++; if (COUNT !== 4'd1) begin n_bad++; $display("FAIL press_held_count: got %0d want 1", COUNT); end
        n_cmp++; if (KEY !== 4'd6)   begin n_bad++; $display("FAIL press_held_key: got %0d want 6", KEY); end
    endtask

    task automatic test_bounce();
        do_reset();
        scan(4'd6); scan(4'd6); scan(4'd9); scan(4'd6); scan(4'd6);
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL bounce_early_valid: got %0d want 0", VALID); end
        scan(4'd6);
        n_cmp++; if (COUNT !== 4'd1) begin n_bad++; $display("FAIL bounce_count: got %0d want 1", COUNT); end
        n_cmp++; if (KEY !== 4'd6)   begin n_bad++; $display("FAIL bounce_key: got %0d want 6", KEY); end
        pop_one();
        idle(20);
        // Two matching scans, then a release timeout: the third scan must start over.
        scan(4'd3); scan(4'd3); idle(20); scan(4'd3);
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL timeout_restart_valid: got %0d want 0", VALID); end
        scan(4'd3); scan(4'd3);
        n_cmp++; if (COUNT !== 4'd1) begin n_bad++; $display("FAIL timeout_push_count: got %0d want 1", COUNT); end
        n_cmp++; if (KEY !== 4'd3)   begin n_bad++; $display("FAIL timeout_push_key: got %0d want 3", KEY); end
    endtask

    task automatic test_repress();
        do_reset();
        press(4'd6); press(4'd6);
        n_cmp++; if (COUNT !== 4'd2) begin n_bad++; $display("FAIL repress_count: got %0d want 2", COUNT); end
        n_cmp++; if (KEY !== 4'd6)   begin n_bad++; $display("FAIL repress_key0: got %0d want 6", KEY); end
        pop_one();
        n_cmp++; if (KEY !== 4'd6)   begin n_bad++; $display("FAIL repress_key1: got %0d want 6", KEY); end
        n_cmp++; if (COUNT !== 4'd1) begin n_bad++; $display("FAIL repress_count1: got %0d want 1", COUNT); end
        pop_one();
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL repress_empty_valid: got %0d want 0", VALID); end
        n_cmp++; if (COUNT !== 4'd0) begin n_bad++; $display("FAIL repress_empty_count: got %0d want 0", COUNT); end
        pop_one();
        n_cmp++; if (COUNT !== 4'd0) begin n_bad++; $display("FAIL underflow_count: got %0d want 0", COUNT); end
        n_cmp++; if (KEY !== 4'd6)   begin n_bad++; $display("FAIL empty_key_hold: got %0d want 6", KEY); end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        scan(4'd5); scan(4'd5);
        {V, H} = 4'd5; Y = 1'b1; tick(); Y = 1'b0;
        POP = 1'b1; tick(); POP = 1'b0;
        n_cmp++; if (COUNT !== 4'd1) begin n_bad++; $display("FAIL empty_pushpop_count: got %0d want 1", COUNT); end
        n_cmp++; if (KEY !== 4'd5)   begin n_bad++; $display("FAIL empty_pushpop_key: got %0d want 5", KEY); end
        idle(30);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) press(4'(i));
        n_cmp++; if (COUNT !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d want 8", COUNT); end
        n_cmp++; if (OVF !== 1'b0)   begin n_bad++; $display("FAIL full_ovf: got %0d want 0", OVF); end
        n_cmp++; if (KEY !== 4'd0)   begin n_bad++; $display("FAIL full_key: got %0d want 0", KEY); end
        // Push of code 8 lands on the same edge as a pop.
        scan(4'd8); scan(4'd8);
        {V, H} = 4'd8; Y = 1'b1; tick(); Y = 1'b0;
        POP = 1'b1; tick(); POP = 1'b0;
        n_cmp++; if (COUNT !== 4'd8) begin n_bad++; $display("FAIL full_pushpop_count: got %0d want 8", COUNT); end
        n_cmp++; if (OVF !== 1'b0)   begin n_bad++; $display("FAIL full_pushpop_ovf: got %0d want 0", OVF); end
        n_cmp++; if (KEY !== 4'd1)   begin n_bad++; $display("FAIL full_pushpop_key: got %0d want 1", KEY); end
        idle(30);
        press(4'd9);
        n_cmp++; if (COUNT !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", COUNT); end
        n_cmp++; if (OVF !== 1'b1)   begin n_bad++; $display("FAIL ovf_flag: got %0d want 1", OVF); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (KEY !== 4'(i)) begin n_bad++; $display("FAIL drain_key[%0d]: got %0d want %0d", i, KEY, i); end
            pop_one();
        end
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %0d want 0", VALID); end
        n_cmp++; if (OVF !== 1'b1)   begin n_bad++; $display("FAIL ovf_sticky: got %0d want 1", OVF); end
        do_reset();
        n_cmp++; if (OVF !== 1'b0)   begin n_bad++; $display("FAIL ovf_cleared: got %0d want 0", OVF); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(4'd3);
        scan(4'd5); scan(4'd5);
        RST = 1'b1; tick(); RST = 1'b0;
        n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %0d want 0", VALID); end
        n_cmp++; if (KEY !== 4'd0)   begin n_bad++; $display("FAIL midreset_key: got %0d want 0", KEY); end
        scan(4'd5);
        n_cmp++; if (COUNT !== 4'd0) begin n_bad++; $display("FAIL midreset_debounce: got %0d want 0", COUNT); end
    endtask

    task automatic test_hold_long();
        do_reset();
        repeat (45) scan(4'd15);
`ifdef KEYPAD_REPEAT_EN
        n_cmp++; if (COUNT !== 4'd4) begin n_bad++; $display("FAIL repeat_count: got %0d want 4", COUNT); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (KEY !== 4'd15) begin n_bad++; $display("FAIL repeat_key[%0d]: got %0d want 15", i, KEY); end
            pop_one();
        end
`else
        n_cmp++; if (COUNT !== 4'd1) begin n_bad++; $display("FAIL hold_count: got %0d want 1", COUNT); end
        n_cmp++; if (KEY !== 4'd15)  begin n_bad++; $display("FAIL hold_key: got %0d want 15", KEY); end
`endif
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_repress();
        test_empty_push_pop();
        test_overflow();
        test_reset_mid();
        test_hold_long();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
